// File: rtl/sme_rng_bank.sv
// Per-lane xorshift32 randomness bank for the SME masked ALU: seed, warm-up, then step per accepted op.
// Optional take counter / reseed request output enabled by SME_RNG_RESEED_REQ_EN.
module sme_rng_bank #(
   parameter int XLEN        = 32,
   parameter int SMAX        = 4,
   parameter int WARM_CYCLES = 16,
   localparam int RMAX       = SMAX + SMAX*(SMAX-1)/2
) (
   input  logic                 g_clk,
   input  logic                 g_reset,
   input  logic                 seed_valid,
   output logic                 seed_ready,
   input  logic [XLEN-1:0]      seed_data,
   input  logic                 reseed,
   input  logic                 rng_take,
`ifdef SME_RNG_RESEED_REQ_EN
   output logic                 reseed_req,
`endif
   output logic                 rng_valid,
   output logic [RMAX*XLEN-1:0] rng
);

   localparam int IDX_W  = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam int WCNT_W = (WARM_CYCLES > 0) ? $clog2(WARM_CYCLES+1) : 1;

   typedef enum logic [1:0] {SEED, WARM, RUN} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [WCNT_W-1:0] wcnt, wcnt_nxt;
   logic              load, step_all;
   logic [XLEN-1:0]   lane [RMAX];

   function automatic logic [XLEN-1:0] xs_step(input logic [XLEN-1:0] x);
      logic [XLEN-1:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state      <= SEED;
         idx        <= '0;
         wcnt       <= '0;
         rng_valid  <= 1'b0;
         seed_ready <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         wcnt       <= wcnt_nxt;
         rng_valid  <= (state_nxt == RUN);
         seed_ready <= (state_nxt == SEED);
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wcnt_nxt  = wcnt;
      load      = 1'b0;
      step_all  = 1'b0;
      case (state)
         SEED: begin
            // A reseed request while seeding restarts the lane sequence and drops any word offered with it.
            if (reseed) begin
               idx_nxt = '0;
            end else if (seed_valid && seed_ready) begin
               load = 1'b1;
               if (idx == IDX_W'(RMAX-1)) begin
                  idx_nxt = '0;
                  if (WARM_CYCLES == 0) begin
                     state_nxt = RUN;
                  end else begin
                     state_nxt = WARM;
                     wcnt_nxt  = WCNT_W'(WARM_CYCLES);
                  end
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         WARM: begin
            step_all = 1'b1;
            wcnt_nxt = wcnt - WCNT_W'(1);
            if (wcnt == WCNT_W'(1)) state_nxt = RUN;
            if (reseed) begin
               state_nxt = SEED;
               idx_nxt   = '0;
            end
         end
         RUN: begin
            step_all = rng_take;
            if (reseed) begin
               state_nxt = SEED;
               idx_nxt   = '0;
            end
         end
         default: begin
            state_nxt = SEED;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         for (int i = 0; i < RMAX; i++) lane[i] <= '0;
      end else begin
         for (int i = 0; i < RMAX; i++) begin
            // Zero seed words are replaced with idx+1 so no lane can lock at zero.
            if (load && (idx == IDX_W'(i)))
               lane[i] <= (seed_data == '0) ? XLEN'(i+1) : seed_data;
            else if (step_all)
               lane[i] <= xs_step(lane[i]);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < RMAX; i++) rng[i*XLEN +: XLEN] = lane[i];
   end

`ifdef SME_RNG_RESEED_REQ_EN
   logic [15:0] tcnt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         tcnt       <= '0;
         reseed_req <= 1'b0;
      end else if ((state_nxt == SEED) && (state != SEED)) begin
         tcnt       <= '0;
         reseed_req <= 1'b0;
      end else if ((state == RUN) && rng_take) begin
         tcnt       <= sat_inc(tcnt);
         reseed_req <= (sat_inc(tcnt) == 16'hFFFF);
      end
   end
`endif

endmodule

// File: tb/tb_sme_rng_bank.sv
// Directed bench for sme_rng_bank: one instance without warm-up, one with a single warm-up step.
module tb_sme_rng_bank;

   localparam int XLEN = 32;
   localparam int SMAX = 4;
   localparam int RMAX = SMAX + SMAX*(SMAX-1)/2;

   logic                 g_clk = 1'b0;
   logic                 g_reset;
   logic                 seed_valid, reseed, rng_take;
   logic                 seed_ready, rng_valid;
   logic [XLEN-1:0]      seed_data;
   logic [RMAX*XLEN-1:0] rng;
   logic                 w_seed_valid, w_reseed, w_rng_take;
   logic                 w_seed_ready, w_rng_valid;
   logic [XLEN-1:0]      w_seed_data;
   logic [RMAX*XLEN-1:0] w_rng;
`ifdef SME_RNG_RESEED_REQ_EN
   logic                 reseed_req, w_reseed_req;
`endif

   int vec_cnt  = 0;
   int miss_cnt = 0;

   always #5 g_clk = ~g_clk;

   sme_rng_bank #(.XLEN(XLEN), .SMAX(SMAX), .WARM_CYCLES(0)) u_nowarm (
      .g_clk(g_clk), .g_reset(g_reset),
      .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data),
      .reseed(reseed), .rng_take(rng_take),
`ifdef SME_RNG_RESEED_REQ_EN
      .reseed_req(reseed_req),
`endif
      .rng_valid(rng_valid), .rng(rng)
   );

   sme_rng_bank #(.XLEN(XLEN), .SMAX(SMAX), .WARM_CYCLES(1)) u_warm1 (
      .g_clk(g_clk), .g_reset(g_reset),
      .seed_valid(w_seed_valid), .seed_ready(w_seed_ready), .seed_data(w_seed_data),
      .reseed(w_reseed), .rng_take(w_rng_take),
`ifdef SME_RNG_RESEED_REQ_EN
      .reseed_req(w_reseed_req),
`endif
      .rng_valid(w_rng_valid), .rng(w_rng)
   );

   function automatic logic [31:0] lane_of(input logic [RMAX*XLEN-1:0] r, input int i);
      return r[i*XLEN +: XLEN];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic seed_word(input logic [31:0] d);
      seed_valid = 1'b1;
      seed_data  = d;
      tick();
      seed_valid = 1'b0;
   endtask

   initial begin
      g_reset = 1'b1;
      seed_valid = 1'b0; seed_data = '0; reseed = 1'b0; rng_take = 1'b0;
      w_seed_valid = 1'b0; w_seed_data = '0; w_reseed = 1'b0; w_rng_take = 1'b0;
      tick();
      check("rst_rng_zero", {31'b0, (rng !== '0)}, 32'd0);
      check("rst_valid", {31'b0, rng_valid}, 32'd0);
      check("rst_ready", {31'b0, seed_ready}, 32'd0);
      g_reset = 1'b0;
      tick();

      // seed 1..10, no warm-up
      for (int i = 0; i < RMAX; i++) begin
         check($sformatf("ready_w%0d", i), {31'b0, seed_ready}, 32'd1);
         check($sformatf("novalid_w%0d", i), {31'b0, rng_valid}, 32'd0);
         seed_word(32'(i+1));
      end
      check("valid_after_seed", {31'b0, rng_valid}, 32'd1);
      check("ready_in_run", {31'b0, seed_ready}, 32'd0);
      check("lane0_seed", lane_of(rng, 0), 32'h00000001);
      check("lane9_seed", lane_of(rng, 9), 32'h0000000A);

      // single take
      rng_take = 1'b1;
      tick();
      rng_take = 1'b0;
      check("lane0_step", lane_of(rng, 0), 32'h00042021);
      check("lane1_step", lane_of(rng, 1), 32'h00084042);
      check("lane9_step", lane_of(rng, 9), 32'h0029414A);
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("hold0_c%0d", c), lane_of(rng, 0), 32'h00042021);
         check($sformatf("hold1_c%0d", c), lane_of(rng, 1), 32'h00084042);
      end

      // take and reseed together
      rng_take = 1'b1; reseed = 1'b1;
      tick();
      rng_take = 1'b0; reseed = 1'b0;
      check("reseed_valid", {31'b0, rng_valid}, 32'd0);
      check("reseed_ready", {31'b0, seed_ready}, 32'd1);
      check("reseed_lane0", lane_of(rng, 0), 32'h04080601);
      tick();
      check("seed_hold_lane0", lane_of(rng, 0), 32'h04080601);

      // zero word on lane 3
      for (int i = 0; i < RMAX; i++) seed_word((i == 3) ? 32'h0 : 32'hDEADBEEF);
      check("zero_valid", {31'b0, rng_valid}, 32'd1);
      check("zero_lane3", lane_of(rng, 3), 32'h00000004);
      check("zero_lane0", lane_of(rng, 0), 32'hDEADBEEF);
      check("zero_lane4", lane_of(rng, 4), 32'hDEADBEEF);
      check("zero_lane9", lane_of(rng, 9), 32'hDEADBEEF);

      // reset after 4 of 10 words
      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      for (int i = 0; i < 4; i++) seed_word(32'h55);
      check("part_lane3", lane_of(rng, 3), 32'h00000055);
      g_reset = 1'b1;
      #1;
      check("midrst_rng_zero", {31'b0, (rng !== '0)}, 32'd0);
      check("midrst_valid", {31'b0, rng_valid}, 32'd0);
      check("midrst_ready", {31'b0, seed_ready}, 32'd0);
      check("midrst_idx", 32'(u_nowarm.idx), 32'd0);
      tick();
      g_reset = 1'b0;
      tick();
      for (int i = 0; i < RMAX-1; i++) seed_word(32'h100 + 32'(i));
      check("nine_words_valid", {31'b0, rng_valid}, 32'd0);
      check("nine_words_lane0", lane_of(rng, 0), 32'h00000100);
      check("nine_words_lane9", lane_of(rng, 9), 32'h00000000);
      seed_word(32'h109);
      check("ten_words_valid", {31'b0, rng_valid}, 32'd1);
      check("ten_words_lane9", lane_of(rng, 9), 32'h00000109);

      // one warm-up step, all lanes seeded with 1
      for (int i = 0; i < RMAX; i++) begin
         w_seed_valid = 1'b1;
         w_seed_data  = 32'h1;
         tick();
      end
      w_seed_valid = 1'b0;
      check("warm_valid_low", {31'b0, w_rng_valid}, 32'd0);
      check("warm_ready_low", {31'b0, w_seed_ready}, 32'd0);
      tick();
      check("warm_valid_high", {31'b0, w_rng_valid}, 32'd1);
      for (int i = 0; i < RMAX; i++)
         check($sformatf("warm_lane%0d", i), lane_of(w_rng, i), 32'h00042021);
      tick();
      check("warm_hold_lane0", lane_of(w_rng, 0), 32'h00042021);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/sme_rng_bank.md
Name: sme_rng_bank

Overview:
- Per-lane PRNG bank that generates the guard randomness for the SME masked ALU.
- Drives all RMAX randomness lanes of the ALU `rng` input:
  - lane 0 is used for remasking;
  - lanes 1..SMAX-1 are used for enmasking;
  - all lanes are used by the DOM AND and the KS adder.
- Software or the TRNG interface seeds it through a valid/ready word stream. It runs a warm-up phase, then advances every lane once per ALU operation the pipeline accepts.

Parameters:
- XLEN, 32, lane width in bits. The update rule below is defined for 32 only.
- SMAX, 4, maximum hardware shares. Defines the localparam RMAX = SMAX + SMAX*(SMAX-1)/2 (10 at default).
- WARM_CYCLES, 16, number of free-running steps after seeding. 0 is legal.

Ports:
- g_clk  in  1  global clock
- g_reset  in  1  asynchronous active-high reset
- seed_valid  in  1  seed word offered
- seed_ready  out  1  bank accepting seed words
- seed_data  in  XLEN  seed word for the current lane
- reseed  in  1  single-cycle pulse requesting a new seed sequence
- rng_take  in  1  ALU consumed the current randomness (ALU valid && ready)
- rng_valid  out  1  randomness is seeded and warmed
- rng  out  RMAX*XLEN  flattened lanes; lane i occupies bits [i*XLEN +: XLEN]

Behaviour:
- States: SEED, WARM, RUN. Lane index `idx` has width $clog2(RMAX). Warm counter `wcnt` has width $clog2(WARM_CYCLES+1).
- Reset (asynchronous, g_reset=1):
  - state=SEED, idx=0, wcnt=0;
  - all lane registers 0, so rng=0;
  - rng_valid=0, seed_ready=0 while reset is asserted.
- Step function per lane, 32-bit xorshift: x^=x<<13; x^=x>>17; x^=x<<5, all truncated to 32 bits.
- SEED state:
  - seed_ready=1.
  - On seed_valid && seed_ready: lane[idx] <= (seed_data==0) ? idx+1 : seed_data, and idx++.
  - When the accepted word is for idx==RMAX-1: idx<=0. Then go to WARM with wcnt<=WARM_CYCLES, or straight to RUN if WARM_CYCLES==0.
  - Lanes that are not yet written keep their old values and do not step.
  - rng_take is ignored.
- WARM state:
  - seed_ready=0, rng_valid=0.
  - All lanes step every cycle and wcnt decrements.
  - When wcnt==1 on the stepping cycle, the next state is RUN. Exactly WARM_CYCLES steps occur.
- RUN state:
  - rng_valid=1 (registered; it rises the cycle after entry to RUN).
  - rng_take=1 steps all lanes, and the new values are visible the next cycle.
  - With no take, the lanes hold.
  - Latency from take to fresh rng is 1 cycle. Back-to-back takes step every cycle.
- reseed:
  - In RUN or WARM: next state SEED, idx<=0, rng_valid<=0.
  - The lanes keep their values until they are overwritten.
  - If rng_take and reseed arrive in the same RUN cycle, the take steps the lanes first, then the bank enters SEED.
  - In SEED, reseed restarts idx at 0.
- Zero-lock guard: a lane never holds 0 after seeding, because zero words are substituted and xorshift maps nonzero values to nonzero values.
- Reset mid-sequence (SEED or WARM): the bank returns to the reset state immediately, and a full RMAX-word seed sequence is required again.
- Outputs rng and rng_valid come straight from registers, with no combinational path from inputs.

Optional Feature:
- Macro: SME_RNG_RESEED_REQ_EN.
- When defined:
  - A 16-bit take counter increments on each RUN-state rng_take.
  - Extra output `reseed_req` (1 bit, registered) asserts when the counter reaches 16'hFFFF and holds.
  - Both the counter and reseed_req clear on entry to SEED.
  - The counter saturates and does not wrap.
- When undefined: no counter and no port, and the behaviour is otherwise identical.

Test Plan:
- Reset, then seed words 1..10 with WARM_CYCLES=0:
  - seed_ready=1 throughout the 10 words;
  - rng_valid=1 one cycle after the 10th word;
  - lane0=0x00000001, lane9=0x0000000A.
- Same as above, then a single rng_take pulse:
  - next cycle lane0=0x00042021 and lane1=step(2)=0x00084042;
  - without a further take, the values hold for 5 cycles.
- Seed with lane3 word=0 and all others 0xDEADBEEF:
  - lane3=0x00000004, and the other lanes=0xDEADBEEF in RUN.
- WARM_CYCLES=1, seed all lanes with 1:
  - rng_valid is low for exactly 1 warm cycle;
  - at RUN every lane=0x00042021.
- reseed pulse in RUN together with rng_take:
  - lanes step once;
  - rng_valid=0 the next cycle;
  - seed_ready=1;
  - a new 10-word sequence restores rng_valid.
- g_reset asserted after 4 of 10 seed words:
  - rng=0, rng_valid=0, idx=0 immediately;
  - after release, all 10 words are needed before RUN.
